// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Port count and lock limit here are the defaults; the top derives its own widths from its parameters.
package ram_arb_pkg;
  localparam int SOC_AXI_ADDR_WIDTH = 32;
  localparam int SOC_AXI_DATA_WIDTH = 64;
  localparam int ARB_NUM_PORTS      = 2;
  localparam int ARB_MAX_LOCK       = 8;
  localparam int RAM_RD_LATENCY     = 1;

  typedef logic [$clog2(ARB_NUM_PORTS)-1:0]  port_idx_t;
  typedef logic [$clog2(ARB_MAX_LOCK+1)-1:0] lock_cnt_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: the first set bit of req at or after start, wrapping around.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);
  always_comb begin
    automatic int k;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      if (!valid && req[k]) begin
        valid  = 1'b1;
        idx    = ($clog2(N))'(k);
        gnt[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port SRAM between NUM_PORTS req/gnt/rvalid requesters.
// Round-robin with a bounded lock; each grant's response is routed back one cycle later.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = ARB_NUM_PORTS,
  parameter int ADDR_WIDTH = SOC_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = SOC_AXI_DATA_WIDTH,
  parameter int MAX_LOCK   = ARB_MAX_LOCK
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  req,
  input  logic [NUM_PORTS-1:0]                  lock,
  input  logic [NUM_PORTS-1:0]                  we,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata,
  output logic [NUM_PORTS-1:0]                  gnt,
  output logic [NUM_PORTS-1:0]                  rvalid,
  output logic [DATA_WIDTH-1:0]                 rdata,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH/8-1:0]               mem_be,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_LOCK+1);

  logic [IW-1:0]        rr_ptr, owner, resp_idx, pick_idx, g_idx;
  logic                 owner_valid, resp_valid, pick_valid, locked, g_any;
  logic [CW-1:0]        lock_cnt;
  logic [NUM_PORTS-1:0] pick_gnt;

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .req   (req),
    .start (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign locked = owner_valid && req[owner] && lock[owner] && (lock_cnt < CW'(MAX_LOCK));

  // Grants are forced off while reset is held, even though req may already be up.
  always_comb begin
    g_idx = locked ? owner : pick_idx;
    g_any = rst_n && (locked || pick_valid);
    gnt   = '0;
    if (g_any) gnt[g_idx] = 1'b1;
  end

  always_comb begin
    mem_req   = g_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (g_any) begin
      mem_we    = we[g_idx];
      mem_addr  = addr[g_idx];
      mem_be    = be[g_idx];
      mem_wdata = wdata[g_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      lock_cnt    <= '0;
      resp_idx    <= '0;
      resp_valid  <= 1'b0;
    end else begin
      resp_valid <= g_any;
      if (g_any) begin
        resp_idx    <= g_idx;
        rr_ptr      <= (g_idx == IW'(NUM_PORTS-1)) ? '0 : g_idx + IW'(1);
        owner       <= g_idx;
        owner_valid <= 1'b1;
        // An expired lock that re-grants the same owner restarts the count at 1.
        lock_cnt    <= (owner_valid && g_idx == owner && lock_cnt < CW'(MAX_LOCK))
                       ? lock_cnt + CW'(1) : CW'(1);
      end else begin
        owner_valid <= 1'b0;
        lock_cnt    <= '0;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (resp_valid) rvalid[resp_idx] = 1'b1;
  end

  assign rdata = mem_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: SRAM model, per-cycle behavioural reference, directed and random stimulus.
module tb_ram_port_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = DW/8;
  localparam int ML = 8;
  localparam int MW = 256;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NP-1:0]         req = '0, lock = '0, we = '0;
  logic [NP-1:0][AW-1:0] addr = '0;
  logic [NP-1:0][BW-1:0] be = '0;
  logic [NP-1:0][DW-1:0] wdata = '0;
  logic [NP-1:0]         gnt, rvalid;
  logic [DW-1:0]         rdata, mem_wdata, mem_rdata = '0;
  logic                  mem_req, mem_we;
  logic [AW-1:0]         mem_addr;
  logic [BW-1:0]         mem_be;

  int n_chk = 0;
  int n_fail = 0;

  ram_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return {16'hC0DE, 16'(i), 16'h5A5A, 16'(i)};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // SRAM macro: one-cycle read latency, byte-enabled writes.
  logic [DW-1:0] sram [MW];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) sram[mem_addr[10:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[10:3]];
      end
    end
  end

  // Reference model: plain integers and a shadow memory, evaluated once per cycle.
  logic [DW-1:0] shadow [MW];
  int m_rr = 0, m_own = 0, m_ov = 0, m_cnt = 0, m_pend = 0, m_pidx = 0, m_prd = 0;
  logic [DW-1:0] m_pdata;

  always @(negedge clk) begin
    automatic int g = -1;
    automatic int k;
    automatic int ix;
    if (!rst_n) begin
      chk("rst_gnt", DW'(gnt), '0);
      chk("rst_rvalid", DW'(rvalid), '0);
      chk("rst_mem_req", DW'(mem_req), '0);
      m_rr = 0; m_ov = 0; m_cnt = 0; m_pend = 0;
    end else begin
      chk("rvalid", DW'(rvalid), m_pend ? DW'(1) << m_pidx : '0);
      if (m_pend && m_prd) chk("rdata", rdata, m_pdata);
      if (m_ov && req[m_own] && lock[m_own] && m_cnt < ML) g = m_own;
      else
        for (int i = 0; i < NP; i++) begin
          k = (m_rr + i) % NP;
          if (g < 0 && req[k]) g = k;
        end
      chk("gnt", DW'(gnt), g >= 0 ? DW'(1) << g : '0);
      chk("mem_req", DW'(mem_req), DW'(g >= 0));
      if (g >= 0) begin
        chk("mem_cmd", {mem_we, mem_be, mem_addr}, {we[g], be[g], addr[g]});
        chk("mem_wdata", mem_wdata, wdata[g]);
        ix = int'(addr[g][10:3]);
        m_pend = 1; m_pidx = g; m_prd = !we[g]; m_pdata = shadow[ix];
        if (we[g])
          for (int b = 0; b < BW; b++)
            if (be[g][b]) shadow[ix][b*8 +: 8] = wdata[g][b*8 +: 8];
        m_cnt = (m_ov && g == m_own && m_cnt < ML) ? m_cnt + 1 : 1;
        m_rr  = (g + 1) % NP;
        m_own = g;
        m_ov  = 1;
      end else begin
        chk("mem_idle", {mem_we, mem_be, mem_addr}, '0);
        m_pend = 0; m_ov = 0; m_cnt = 0;
      end
    end
  end

  task automatic clr();
    req = '0; lock = '0; we = '0; addr = '0; be = '0; wdata = '0;
  endtask

  task automatic set_port(input int p, input logic l, input logic w, input logic [AW-1:0] a,
                          input logic [BW-1:0] b, input logic [DW-1:0] d);
    req[p] = 1'b1; lock[p] = l; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  // Leaves the bench at posedge+1 with reset just released.
  task automatic do_reset();
    next();
    rst_n = 1'b0; clr();
    repeat (2) next();
    rst_n = 1'b1;
  endtask

  logic [NP-1:0] gnt_seen;

  initial begin
    for (int i = 0; i < MW; i++) begin sram[i] = init_word(i); shadow[i] = init_word(i); end
    repeat (2) next();

    // Reset release with port 0 reading 0x40.
    rst_n = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'h40, '1, '0);
    @(negedge clk); chk("t1_gnt", DW'(gnt), 64'h1);
    next(); clr();
    @(negedge clk); chk("t1_rvalid", DW'(rvalid), 64'h1); chk("t1_rdata", rdata, init_word(8));

    // Both ports, no lock: strict alternation.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      clr();
      if (c < 6) begin set_port(0, 1'b0, 1'b0, 32'h8, '1, '0); set_port(1, 1'b0, 1'b0, 32'h10, '1, '0); end
      @(negedge clk);
      if (c < 6) chk("t2_gnt", DW'(gnt), (c % 2) ? 64'h2 : 64'h1);
      if (c > 0) chk("t2_rvalid", DW'(rvalid), ((c - 1) % 2) ? 64'h2 : 64'h1);
      next();
    end

    // Port 1 locked against a busy port 0: 8 grants, then port 0, then port 1.
    do_reset();
    set_port(0, 1'b0, 1'b0, 32'h0, '1, '0);
    @(negedge clk); chk("t3_pre", DW'(gnt), 64'h1);
    next();
    for (int c = 0; c < 12; c++) begin
      set_port(0, 1'b0, 1'b0, 32'h0, '1, '0);
      set_port(1, 1'b1, 1'b0, 32'h18, '1, '0);
      @(negedge clk); chk("t3_gnt", DW'(gnt), (c == 8) ? 64'h1 : 64'h2);
      next();
    end

    // Port 0 alone with lock: served every cycle across the lock expiry.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_port(0, 1'b1, 1'b0, 32'h20, '1, '0);
      @(negedge clk); chk("t4_gnt", DW'(gnt), 64'h1);
      next();
    end

    // Write then read of the same word from the other port.
    do_reset();
    set_port(0, 1'b0, 1'b1, 32'h80, 8'h0F, 64'h11223344_DEADBEEF);
    @(negedge clk); chk("t5_wgnt", DW'(gnt), 64'h1);
    next(); clr();
    set_port(1, 1'b0, 1'b0, 32'h80, '1, '0);
    @(negedge clk); chk("t5_rgnt", DW'(gnt), 64'h2); chk("t5_wrv", DW'(rvalid), 64'h1);
    next(); clr();
    @(negedge clk); chk("t5_rrv", DW'(rvalid), 64'h2); chk("t5_rdata", DW'(rdata[31:0]), 64'hDEADBEEF);
    next();

    // Reset right after a grant drops the pending response.
    set_port(0, 1'b0, 1'b0, 32'h40, '1, '0);
    @(negedge clk); chk("t6_gnt", DW'(gnt), 64'h1);
    next(); rst_n = 1'b0; clr();
    @(negedge clk); chk("t6_rst_rv", DW'(rvalid), 64'h0);
    next(); next(); rst_n = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'h0, '1, '0); set_port(1, 1'b0, 1'b0, 32'h8, '1, '0);
    @(negedge clk); chk("t6_first", DW'(gnt), 64'h1); chk("t6_no_rv", DW'(rvalid), 64'h0);
    next();
    @(negedge clk); chk("t6_second", DW'(gnt), 64'h2);

    // Random traffic; an ungranted request is held unchanged until it wins.
    do_reset();
    gnt_seen = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++)
        if (!(req[p] && !gnt_seen[p])) begin
          req[p]   = ($urandom_range(0, 3) != 0);
          lock[p]  = ($urandom_range(0, 2) == 0);
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = AW'($urandom_range(0, 31)) << 3;
          be[p]    = BW'($urandom);
          wdata[p] = {$urandom, $urandom};
        end
      @(negedge clk); gnt_seen = gnt;
      next();
    end
    clr();
    repeat (2) next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
